// File: rtl/status_reader.sv
// Bus-side reader and interrupt generator for the sticky status register.
// Snapshots status on request, optionally pulses clear, then blanks for the clear sequence.
module status_reader #(
  parameter int unsigned          STATUS_W    = 13,
  parameter logic [STATUS_W-1:0]  STICKY_MASK = 13'h126D,
  parameter int unsigned          BLACKOUT    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [STATUS_W-1:0] status_in,
  input  logic [STATUS_W-1:0] irq_en,
  input  logic                rd_req,
  input  logic                rd_clr,
  output logic                rd_ready,
  output logic                rd_valid,
  output logic [STATUS_W-1:0] rd_data,
  output logic                clear_out,
  output logic                irq
);

  localparam int unsigned CNT_W = $clog2(BLACKOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BLACKOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             clr_lat;

  assign rd_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      clear_out <= 1'b0;
      irq       <= 1'b0;
      cnt       <= '0;
      clr_lat   <= 1'b0;
    end else begin
      rd_valid  <= 1'b0;
      clear_out <= 1'b0;
      irq       <= 1'b0;
      case (state)
        IDLE: begin
          if (rd_req) begin
            rd_data  <= status_in;
            clr_lat  <= rd_clr;
            // Registered outputs are set on the capture edge so they are visible during CAPTURE.
            rd_valid  <= 1'b1;
            clear_out <= rd_clr;
            state     <= CAPTURE;
          end else begin
            irq <= |(status_in & STICKY_MASK & irq_en);
          end
        end
        CAPTURE: begin
          if (clr_lat) begin
            cnt   <= CNT_LOAD;
            state <= HOLD;
          end else begin
            state <= IDLE;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_status_reader.sv
// Self-checking bench for status_reader: directed scenarios plus random traffic,
// checked every cycle against a cycle-count timeline model (BLACKOUT=4 and BLACKOUT=1).
module tb_status_reader;

  localparam int unsigned W = 13;
  localparam logic [W-1:0] MASK = 13'h126D;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] status_in, irq_en;
  logic         rd_req, rd_clr;

  logic         rdy0, val0, clr0, irq0;
  logic [W-1:0] dat0;
  logic         rdy1, val1, clr1, irq1;
  logic [W-1:0] dat1;

  always #5 clk = ~clk;

  status_reader #(.STATUS_W(W), .STICKY_MASK(MASK), .BLACKOUT(4)) u_dut0 (
    .clk(clk), .rst(rst), .status_in(status_in), .irq_en(irq_en),
    .rd_req(rd_req), .rd_clr(rd_clr), .rd_ready(rdy0), .rd_valid(val0),
    .rd_data(dat0), .clear_out(clr0), .irq(irq0)
  );

  status_reader #(.STATUS_W(W), .STICKY_MASK(MASK), .BLACKOUT(1)) u_dut1 (
    .clk(clk), .rst(rst), .status_in(status_in), .irq_en(irq_en),
    .rd_req(rd_req), .rd_clr(rd_clr), .rd_ready(rdy1), .rd_valid(val1),
    .rd_data(dat1), .clear_out(clr1), .irq(irq1)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit have_exp = 1'b0;

  // Model: a request accepted in cycle N makes the reader busy until cycle
  // N+2 (plain) or N+2+BLACKOUT (read-to-clear); outputs appear in cycle N+1.
  int           idle_from [2];
  logic         e_valid   [2];
  logic         e_clear   [2];
  logic         e_irq     [2];
  logic [W-1:0] e_data    [2];
  int           n_acc [2] = '{0, 0};
  int           n_cexp[2] = '{0, 0};
  int           n_val [2] = '{0, 0};
  int           n_cobs[2] = '{0, 0};

  task automatic chk(input string tag, input int inst, input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s[%0d] cyc=%0d observed=%h expected=%h", tag, inst, cyc, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic [W-1:0] s, input logic [W-1:0] en,
                      input logic q, input logic c);
    logic         o_rdy, o_val, o_clr, o_irq;
    logic [W-1:0] o_dat;
    bit           idle_now, acc;
    int           bo;
    rst = r; status_in = s; irq_en = en; rd_req = q; rd_clr = c;
    for (int i = 0; i < 2; i++) begin
      bo = (i == 0) ? 4 : 1;
      if (i == 0) {o_rdy, o_val, o_clr, o_irq, o_dat} = {rdy0, val0, clr0, irq0, dat0};
      else        {o_rdy, o_val, o_clr, o_irq, o_dat} = {rdy1, val1, clr1, irq1, dat1};
      if (have_exp) begin
        chk("rd_ready",  i, W'(o_rdy), W'(cyc >= idle_from[i]));
        chk("rd_valid",  i, W'(o_val), W'(e_valid[i]));
        chk("clear_out", i, W'(o_clr), W'(e_clear[i]));
        chk("irq",       i, W'(o_irq), W'(e_irq[i]));
        chk("rd_data",   i, o_dat, e_data[i]);
        n_val[i]  += (o_val === 1'b1) ? 1 : 0;
        n_cobs[i] += (o_clr === 1'b1) ? 1 : 0;
      end
      idle_now = (cyc >= idle_from[i]);
      if (r) begin
        idle_from[i] = cyc + 1;
        e_valid[i] = 1'b0; e_clear[i] = 1'b0; e_irq[i] = 1'b0; e_data[i] = '0;
      end else begin
        acc = idle_now && q;
        e_valid[i] = acc;
        e_clear[i] = acc && c;
        e_irq[i]   = idle_now && !acc && ((s & MASK & en) != '0);
        if (acc) begin
          e_data[i]    = s;
          idle_from[i] = cyc + (c ? 2 + bo : 2);
          n_acc[i]++;
          if (c) n_cexp[i]++;
        end
      end
    end
    if (r) have_exp = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    logic [W-1:0] rs, re;
    idle_from = '{0, 0};
    rst = 1'b1; status_in = '0; irq_en = '0; rd_req = 1'b0; rd_clr = 1'b0;
    #1;

    // Reset with everything set, irq rises one cycle after release
    step(1, 13'h1FFF, 13'h1FFF, 0, 0);
    step(1, 13'h1FFF, 13'h1FFF, 0, 0);
    repeat (3) step(0, 13'h1FFF, 13'h1FFF, 0, 0);

    // Plain read
    step(0, 13'h0A53, 13'h0000, 1, 0);
    repeat (3) step(0, 13'h0A53, 13'h0000, 0, 0);

    // Read-to-clear: bits 0 and 9 set; emulated register clears sticky bits before N+6
    step(0, 13'h0201, 13'h1FFF, 1, 1);
    repeat (3) step(0, 13'h0201, 13'h1FFF, 0, 0);
    repeat (5) step(0, 13'h0000, 13'h1FFF, 0, 0);

    // Interrupt masking
    repeat (2) step(0, 13'h0002, 13'h1FFF, 0, 0);
    repeat (2) step(0, 13'h0004, 13'h0004, 0, 0);
    repeat (2) step(0, 13'h0004, 13'h0000, 0, 0);

    // Request held during HOLD
    step(0, 13'h1041, 13'h1FFF, 1, 1);
    step(0, 13'h1041, 13'h1FFF, 0, 0);
    repeat (5) step(0, 13'h0840, 13'h1FFF, 1, 0);
    repeat (4) step(0, 13'h0840, 13'h1FFF, 0, 0);

    // Reset in the middle of HOLD
    step(0, 13'h0020, 13'h1FFF, 1, 1);
    repeat (2) step(0, 13'h0020, 13'h1FFF, 0, 0);
    step(1, 13'h0020, 13'h1FFF, 0, 0);
    repeat (6) step(0, 13'h0020, 13'h1FFF, 0, 0);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      rs = W'($urandom);
      re = W'($urandom);
      step(($urandom_range(0, 49) == 0), rs, re, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));
    end
    repeat (8) step(0, 13'h0000, 13'h0000, 0, 0);

    for (int i = 0; i < 2; i++) begin
      chk("valid_count", i, W'(n_val[i]),  W'(n_acc[i]));
      chk("clear_count", i, W'(n_cobs[i]), W'(n_cexp[i]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
